// File: rtl/ifetch_pkg.sv
// Shared types, constants and the 6502 opcode length decode used by the
// byte-serial instruction fetch stage.
package ifetch_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   localparam int INSTR_MAX_BYTES = 3;

   // Instruction length in bytes (1..3) from the opcode's aaa/bbb/cc fields.
   // cc=11 opcodes are illegal on the 6502 and are treated as one-byte NOPs.
   function automatic logic [1:0] instr_len(input logic [7:0] opcode);
      logic [1:0] cc;
      logic [2:0] bbb;
      logic [2:0] aaa;
      logic [1:0] len;
      cc  = opcode[1:0];
      bbb = opcode[4:2];
      aaa = opcode[7:5];
      len = 2'd2;
      if (cc == 2'b11) begin
         len = 2'd1;
      end else if (cc == 2'b01) begin
         if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
      end else begin
         case (bbb)
            3'b010, 3'b110: len = 2'd1;
            3'b011, 3'b111: len = 2'd3;
            3'b000: begin
               if (cc == 2'b00) begin
                  if (aaa == 3'b001) len = 2'd3;
                  else if (aaa == 3'b000 || aaa == 3'b010 || aaa == 3'b011) len = 2'd1;
               end
            end
            default: len = 2'd2;
         endcase
      end
      return len;
   endfunction

endpackage

// File: rtl/instr_fetch_t.sv
// Byte-serial instruction fetch: reads opcode and operand bytes one at a
// time, assembles {op_hi, op_lo, opcode} and hands it to decode over a
// valid/ready handshake. A redirect reloads the PC and flushes the fetch;
// a granted read that is still in flight is drained and its byte dropped.
module instr_fetch_t
   import ifetch_pkg::*;
#(
   parameter int                       MEM_ADDR_SIZE = 16,
   parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC      = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     redirect_i,
   input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
   output logic                     mem_req_o,
   output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [7:0]               mem_rdata_i,
   output logic                     instr_valid_o,
   input  logic                     instr_ready_i,
   output logic [23:0]              instr_o,
   output logic [1:0]               instr_len_o,
   output logic [MEM_ADDR_SIZE-1:0] instr_pc_o
);

   localparam int                       BUF_BITS = INSTR_MAX_BYTES * 8;
   localparam logic [MEM_ADDR_SIZE-1:0] PC_STEP  = {{(MEM_ADDR_SIZE-1){1'b0}}, 1'b1};

   fetch_state_t             state;
   fetch_state_t             state_next;
   logic [MEM_ADDR_SIZE-1:0] fetch_pc;
   logic [MEM_ADDR_SIZE-1:0] pc_q;
   logic [1:0]               byte_cnt;
   logic [1:0]               len_q;
   logic [1:0]               cur_len;
   logic [BUF_BITS-1:0]      buffer;
   logic                     byte_rx;
   logic                     accept;
   logic                     outstanding;
   logic                     last_byte;

   // Handshake terms; the opcode byte supplies its own length on arrival
   always_comb begin
      byte_rx     = (state == WAIT) && mem_rvalid_i;
      accept      = (state == HOLD) && instr_ready_i;
      outstanding = (state == WAIT) || (state == DRAIN) || ((state == REQ) && mem_gnt_i);
      cur_len     = (byte_cnt == 2'd0) ? instr_len(mem_rdata_i) : len_q;
      last_byte   = ((byte_cnt + 2'd1) == cur_len);
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= REQ;
      else       state <= state_next;
   end

   // Next state; redirect overrides everything and drains a granted read
   always_comb begin
      state_next = state;
      if (redirect_i) begin
         if ((state == WAIT || state == DRAIN) && mem_rvalid_i) state_next = REQ;
         else if (outstanding)                                  state_next = DRAIN;
         else                                                   state_next = REQ;
      end else begin
         case (state)
            REQ:     if (mem_gnt_i)     state_next = WAIT;
            WAIT:    if (mem_rvalid_i)  state_next = last_byte ? HOLD : REQ;
            HOLD:    if (instr_ready_i) state_next = REQ;
            DRAIN:   if (mem_rvalid_i)  state_next = REQ;
            default:                    state_next = REQ;
         endcase
      end
   end

   // Fetch PC, byte counter and assembly buffer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc <= RESET_PC;
         byte_cnt <= 2'd0;
         buffer   <= '0;
         len_q    <= 2'd0;
         pc_q     <= '0;
      end else if (redirect_i) begin
         fetch_pc <= redirect_pc_i;
         byte_cnt <= 2'd0;
         buffer   <= '0;
      end else if (byte_rx) begin
         case (byte_cnt)
            2'd0:    buffer[7:0]   <= mem_rdata_i;
            2'd1:    buffer[15:8]  <= mem_rdata_i;
            default: buffer[23:16] <= mem_rdata_i;
         endcase
         fetch_pc <= fetch_pc + PC_STEP;
         if (byte_cnt == 2'd0) begin
            pc_q  <= fetch_pc;
            len_q <= cur_len;
         end
         if (!last_byte) byte_cnt <= byte_cnt + 2'd1;
      end else if (accept) begin
         buffer   <= '0;
         byte_cnt <= 2'd0;
      end
   end

   // Outputs; the request is held low for as long as reset is asserted
   always_comb begin
      mem_req_o     = (state == REQ) && !rst_i;
      mem_addr_o    = fetch_pc;
      instr_valid_o = (state == HOLD);
      instr_o       = buffer;
      instr_len_o   = len_q;
      instr_pc_o    = pc_q;
   end

endmodule

// File: doc/instr_fetch_t.md
Name: instr_fetch_t

Overview:
- Byte-serial instruction fetch stage that sits directly upstream of decode.
- Issues one-byte reads to program memory starting at the PC and decodes the opcode's instruction length (1-3 bytes).
- Assembles the opcode plus operand bytes into a 24-bit word laid out exactly as decode consumes it.
- Hands the word to decode over a valid/ready handshake.
- Supports PC redirect for branches, jumps and reset vectors.

Parameters:
- MEM_ADDR_SIZE, 16, width of the program address / PC.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- redirect_i  in  1  load a new PC and flush the in-flight fetch
- redirect_pc_i  in  MEM_ADDR_SIZE  new PC
- mem_req_o  out  1  byte read request
- mem_addr_o  out  MEM_ADDR_SIZE  request address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; arrives at least 1 cycle after grant
- mem_rdata_i  in  8  read byte
- instr_valid_o  out  1  assembled instruction available
- instr_ready_i  in  1  decode accepts
- instr_o  out  24  {op_hi, op_lo, opcode}; opcode in [7:0]; unused bytes zero
- instr_len_o  out  2  1, 2 or 3
- instr_pc_o  out  MEM_ADDR_SIZE  address of the opcode byte

Behaviour:
- Reset (async): state=REQ, fetch_pc=RESET_PC, byte_cnt=0. All outputs zero: mem_req_o, instr_valid_o, instr_o, instr_len_o, instr_pc_o.
- While rst_i is high, mem_req_o=0. Reset mid-transaction discards everything; any later rvalid belonging to the old request is ignored.
- States: REQ, WAIT, HOLD, DRAIN.
  - REQ: mem_req_o=1, mem_addr_o=fetch_pc. On gnt -> WAIT.
  - WAIT: on rvalid, store the byte at index byte_cnt and increment fetch_pc (16-bit wrap FFFF->0000).
    - If byte_cnt==0: latch opcode, instr_pc=fetch_pc, len=instr_len(opcode).
    - If bytes collected == len -> HOLD, else byte_cnt++ and -> REQ.
  - HOLD: instr_valid_o=1; instr_o, instr_len_o and instr_pc_o stable until instr_ready_i. On accept: clear the assembly buffer, byte_cnt=0, -> REQ.
  - DRAIN: entered on redirect while a granted request is outstanding (WAIT, or REQ with gnt the same cycle). mem_req_o=0; wait for rvalid, discard the byte, -> REQ.
- Only one outstanding memory request at any time.
- Redirect has highest priority, in any state:
  - fetch_pc=redirect_pc_i, byte_cnt=0, buffer cleared, instr_valid_o=0 next cycle.
  - Next state is DRAIN if a request is outstanding, else REQ.
  - Redirect coincident with a HOLD accept: the transfer completes (decode keeps the word) and the redirect still applies.
  - Redirect in the same cycle as the rvalid of an outstanding request: the byte is discarded, -> REQ.
- Latency, zero-wait memory (gnt in the request cycle, rvalid the next cycle):
  - 1-byte instruction: REQ c0, WAIT c1, valid c2.
  - Each extra byte adds 2 cycles.
  - No prefetch overlap.
- Length rule, 6502 encoding: cc=op[1:0], bbb=op[4:2], aaa=op[7:5].
  - cc=01: bbb 011/110/111 -> 3, else 2.
  - cc=00/10:
    - bbb 010/110 -> 1; bbb 011/111 -> 3; bbb 001/100/101 -> 2.
    - bbb 000 with cc=00: aaa 000/010/011 -> 1 (BRK/RTI/RTS), aaa 001 -> 3 (JSR), else 2.
    - bbb 000 with cc=10: 2.
  - cc=11: 1 (illegal, treated as NOP-length).
- A multi-byte instruction spanning FFFF->0000 fetches its operands from 0000 onward.

Decomposition:
- Package ifetch_pkg:
  - fetch_state_t enum {REQ, WAIT, HOLD, DRAIN}.
  - INSTR_MAX_BYTES=3.
  - Pure function instr_len(opcode) returning a 2-bit length.
- No sub-module is needed: the length decode is the package function, and the FSM, PC and byte buffer live in instr_fetch_t.

Test Plan:
- Zero-wait memory at RESET_PC=0000 holding A9 42 (LDA #$42), ready=1 -> valid at cycle 4 after reset release, instr_o=24'h0042A9, len=2, instr_pc=0000; next request address 0002.
- Bytes AD 34 12 at 0010, redirect_pc=0010, instr_ready_i held 0 for 5 cycles -> instr_o=24'h1234AD, len=3 held stable all 5 cycles; exactly 3 memory requests; single transfer on ready.
- Opcode EA (NOP) at FFFF -> len=1, instr_pc=FFFF, next fetch address 0000. Opcode 4C (JMP) at FFFE -> operands read from FFFF and 0000.
- Redirect to 0200 asserted in WAIT, rvalid delayed 3 cycles -> mem_req_o=0 until the stale rvalid, stale byte discarded, next request address 0200, no valid with stale data.
- Assert rst_i in HOLD with valid=1 -> instr_valid_o, mem_req_o and instr_o all 0 immediately. After release, the first request address is RESET_PC.
- Sweep all 256 opcodes through the length function -> matches the rule above, e.g. 00->1, 20->3, 60->1, 10->2, 0A->1, BE->3, 03->1.
